// File: rtl/update_scheduler_pkg.sv
// Shared types for the update scheduler: FSM state encoding and the queued job record.
package update_scheduler_pkg;

    localparam int unsigned W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } sched_state_t;

    typedef struct packed {
        logic         id;
        logic [W-1:0] x_0;
        logic [W-1:0] x_1;
        logic [W-1:0] delta_0;
        logic [W-1:0] delta_1;
    } upd_job_t;

endpackage

// File: rtl/update_scheduler_sync_fifo.sv
// Synchronous FIFO with count-based full/empty; push is dropped when full, pop when empty.
module update_scheduler_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0]   count_q;
    logic             push_en, pop_en;

    assign full_o  = (count_q == (AddrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_en) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/update_scheduler.sv
// Round-robin arbitration of two job requesters into a FIFO, and an FSM that issues each job
// to the updater, waits for done or timeout, and returns a tagged response.
module update_scheduler
    import update_scheduler_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned Timeout = 255
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [1:0]     req_valid_i,
    output logic [1:0]     req_ready_o,
    input  logic [8*W-1:0] req_data_i,
    output logic [W-1:0]   upd_x_0_o,
    output logic [W-1:0]   upd_x_1_o,
    output logic [W-1:0]   upd_delta_0_o,
    output logic [W-1:0]   upd_delta_1_o,
    output logic           upd_start_o,
    input  logic           upd_done_i,
    output logic           resp_valid_o,
    output logic           resp_id_o,
    output logic           resp_timeout_o,
    output logic           busy_o
);
    localparam int unsigned TimerW = $clog2(Timeout + 1);

    sched_state_t      state_q;
    logic [TimerW-1:0] timer_q;
    logic              rr_q;
    logic [1:0]        grant;
    logic              push, push_id, pop;
    logic              fifo_full, fifo_empty;
    upd_job_t          push_job, pop_job;
    logic [W-1:0]      x_0_q, x_1_q, delta_0_q, delta_1_q;
    logic              job_id_q, start_q, resp_valid_q, resp_id_q, resp_timeout_q;

    // Priority starts at the round-robin pointer.
    always_comb begin
        grant = 2'b00;
        if (!rr_q) begin
            if (req_valid_i[0])      grant = 2'b01;
            else if (req_valid_i[1]) grant = 2'b10;
        end else begin
            if (req_valid_i[1])      grant = 2'b10;
            else if (req_valid_i[0]) grant = 2'b01;
        end
    end

    assign req_ready_o = grant & {2{~fifo_full}};
    assign push        = |req_ready_o;
    assign push_id     = grant[1];
    assign push_job    = upd_job_t'({push_id, push_id ? req_data_i[8*W-1:4*W]
                                                      : req_data_i[4*W-1:0]});
    assign pop         = (state_q == StIdle) & ~fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b0;
        end else if (push) begin
            rr_q <= ~push_id;
        end
    end

    update_scheduler_sync_fifo #(
        .Width ($bits(upd_job_t)),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_job),
        .pop_i   (pop),
        .data_o  (pop_job),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            x_0_q          <= '0;
            x_1_q          <= '0;
            delta_0_q      <= '0;
            delta_1_q      <= '0;
            job_id_q       <= 1'b0;
            start_q        <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        x_0_q     <= pop_job.x_0;
                        x_1_q     <= pop_job.x_1;
                        delta_0_q <= pop_job.delta_0;
                        delta_1_q <= pop_job.delta_1;
                        job_id_q  <= pop_job.id;
                        start_q   <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // done takes priority over a timeout in the same cycle
                    if (upd_done_i) begin
                        resp_valid_q   <= 1'b1;
                        resp_id_q      <= job_id_q;
                        resp_timeout_q <= 1'b0;
                        state_q        <= StResp;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        if (timer_q == TimerW'(Timeout - 1)) begin
                            resp_valid_q   <= 1'b1;
                            resp_id_q      <= job_id_q;
                            resp_timeout_q <= 1'b1;
                            state_q        <= StResp;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign upd_x_0_o      = x_0_q;
    assign upd_x_1_o      = x_1_q;
    assign upd_delta_0_o  = delta_0_q;
    assign upd_delta_1_o  = delta_1_q;
    assign upd_start_o    = start_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_id_o      = resp_id_q;
    assign resp_timeout_o = resp_timeout_q;
    assign busy_o         = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_update_scheduler.sv
// Randomized and directed scoreboard bench for update_scheduler.
module tb_update_scheduler;
    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          pcyc;
    } job_t;

    typedef struct {
        int id;
        bit to;
        int rcyc;
    } resp_t;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [8*W-1:0] req_data;
    logic [W-1:0]   upd_x_0, upd_x_1, upd_delta_0, upd_delta_1;
    logic           upd_start;
    logic           upd_done = 1'b0;
    logic           resp_valid, resp_id, resp_timeout, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    job_t        exp_q[$];
    resp_t       resp_q[$];
    int          model_count;
    bit          rr;
    int          last_resp;
    logic [31:0] cur_ops;
    int          done_at;
    bit          force_done = 1'b0;
    bit          dly_never  = 1'b0;
    int          dly_lo     = 1;
    int          dly_hi     = 1;

    update_scheduler #(
        .Depth   (DEPTH),
        .Timeout (TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .upd_x_0_o      (upd_x_0),
        .upd_x_1_o      (upd_x_1),
        .upd_delta_0_o  (upd_delta_0),
        .upd_delta_1_o  (upd_delta_1),
        .upd_start_o    (upd_start),
        .upd_done_i     (upd_done),
        .resp_valid_o   (resp_valid),
        .resp_id_o      (resp_id),
        .resp_timeout_o (resp_timeout),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=missing required=event cycle=%0d", name, cyc);
    endtask

    task automatic model_reset();
        exp_q.delete();
        resp_q.delete();
        model_count = 0;
        rr          = 1'b0;
        last_resp   = -10;
        cur_ops     = '0;
        done_at     = -1;
        force_done  = 1'b0;
    endtask

    // Updater stand-in: done fires at the cycle scheduled by the monitor, or when forced.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            upd_done = force_done || (done_at >= 0 && cyc == done_at);
        end
    end

    // Monitor and scoreboard.
    initial begin : monitor
        job_t        j;
        resp_t       r;
        logic [1:0]  e;
        logic [31:0] ops;
        int          d, exp_s;
        forever begin
            @(negedge clk);
            if (!rst_ni) continue;
            ops = {upd_x_0, upd_x_1, upd_delta_0, upd_delta_1};
            if (upd_start) begin
                if (model_count > 0) model_count--;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_start");
                end else begin
                    j = exp_q.pop_front();
                    check("start_operands", ops, j.data);
                    exp_s = ((j.pcyc > last_resp) ? j.pcyc : last_resp) + 2;
                    check("start_cycle", cyc, exp_s);
                    cur_ops = j.data;
                    d = dly_never ? -1 : int'($urandom_range(dly_hi, dly_lo));
                    done_at = (d >= 1) ? cyc + d : -1;
                    r.id = j.id;
                    r.to = (d < 1) || (d > TIMEOUT);
                    r.rcyc = cyc + (r.to ? TIMEOUT + 1 : d + 1);
                    resp_q.push_back(r);
                end
            end else begin
                check("operands_stable", ops, cur_ops);
            end

            e = 2'b00;
            if (model_count < DEPTH) begin
                if (!rr) e = req_valid[0] ? 2'b01 : (req_valid[1] ? 2'b10 : 2'b00);
                else     e = req_valid[1] ? 2'b10 : (req_valid[0] ? 2'b01 : 2'b00);
            end
            check("req_ready", req_ready, e);
            for (int i = 0; i < 2; i++) begin
                if (e[i]) begin
                    j.id   = i;
                    j.data = req_data[i*32 +: 32];
                    j.pcyc = cyc;
                    exp_q.push_back(j);
                    model_count++;
                    rr = (i == 0);
                end
            end

            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    r = resp_q.pop_front();
                    check("resp_id", resp_id, r.id);
                    check("resp_timeout", resp_timeout, r.to);
                    check("resp_cycle", cyc, r.rcyc);
                end
                last_resp = cyc;
                done_at   = -1;
            end
        end
    end

    task automatic send(input int i, input logic [31:0] d);
        bit ok = 1'b0;
        req_data[i*32 +: 32] = d;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("send_accept");
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            #1;
            if (model_count == 0 && exp_q.size() == 0 && resp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain");
        @(negedge clk);
        #1;
        check("busy_idle", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_dly(input bit never, input int lo, input int hi);
        dly_never = never;
        dly_lo    = lo;
        dly_hi    = hi;
    endtask

    initial begin
        int n0, n1;
        logic [1:0] a;
        rst_ni    = 1'b0;
        req_valid = 2'b00;
        req_data  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {req_ready, upd_x_0, upd_x_1, upd_delta_0, upd_delta_1,
                                upd_start, resp_valid, resp_id, resp_timeout, busy}, '0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // single job, done 10 cycles after start
        set_dly(1'b0, 10, 10);
        send(0, {8'd25, 8'd43, 8'd50, 8'd25});
        wait_idle();

        // both requesters held valid, 4 jobs each
        set_dly(1'b0, 3, 3);
        n0 = 0;
        n1 = 0;
        req_data  = {$urandom, $urandom};
        req_valid = 2'b11;
        for (int g = 0; g < 500 && (n0 < 4 || n1 < 4); g++) begin
            @(negedge clk);
            a = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (a[0]) begin
                n0++;
                req_data[31:0] = $urandom;
                if (n0 == 4) req_valid[0] = 1'b0;
            end
            if (a[1]) begin
                n1++;
                req_data[63:32] = $urandom;
                if (n1 == 4) req_valid[1] = 1'b0;
            end
        end
        req_valid = 2'b00;
        wait_idle();

        // stream on req0 with done never asserted: backpressure and timeouts
        set_dly(1'b1, 1, 1);
        for (int k = 0; k < 6; k++) send(0, $urandom);
        wait_idle();

        // done exactly on the timeout cycle wins
        set_dly(1'b0, TIMEOUT, TIMEOUT);
        send(1, $urandom);
        wait_idle();

        // stray done in IDLE, then done in the ISSUE cycle, both ignored
        force_done = 1'b1;
        @(posedge clk);
        #1;
        force_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        set_dly(1'b1, 1, 1);
        send(1, $urandom);
        @(posedge clk);
        #1;
        force_done = 1'b1;
        @(posedge clk);
        #1;
        force_done = 1'b0;
        wait_idle();

        // randomized traffic
        set_dly(1'b0, 1, 8);
        for (int c = 0; c < 400; c++) begin
            req_valid = 2'($urandom);
            req_data  = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        wait_idle();

        // async reset mid-WAIT with jobs queued
        set_dly(1'b1, 1, 1);
        for (int k = 0; k < 4; k++) send(k % 2, $urandom);
        repeat (20) @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check("async_reset_outputs", {req_ready, upd_x_0, upd_x_1, upd_delta_0, upd_delta_1,
                                      upd_start, resp_valid, resp_id, resp_timeout, busy}, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        set_dly(1'b0, 10, 10);
        send(0, {8'd25, 8'd43, 8'd50, 8'd25});
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
